// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32I-subset decode stage with
// valid/ready handshake, flush and a downstream transfer counter.
package rv_pkg;
   typedef enum logic [3:0] {
      OP_NOP,
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR,
      OP_XOR,
      OP_SLL,
      OP_SRL,
      OP_SRA,
      OP_SLT,
      OP_SLTU
   } alu_operations_e;
endpackage

module rv_decode_stage
   import rv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             instr_valid_i,
   output logic             instr_ready_o,
   input  logic [31:0]      instr_i,
   input  logic [XLEN-1:0]  pc_i,
   output logic             dec_valid_o,
   input  logic             dec_ready_i,
   output logic [4:0]       rs_addr_a_o,
   output logic [4:0]       rs_addr_b_o,
   output logic [4:0]       rd_addr_o,
   output logic [XLEN-1:0]  imm_o,
   output logic [XLEN-1:0]  branch_target_o,
   output alu_operations_e  alu_ctrl_o,
   output logic             alu_src_o,
   output logic             rd_we_o,
   output logic             branch_o,
   output logic             alu_dst_o,
   output logic             mem_we_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] dec_count_o
);
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_b, imm_sel;
   logic            accept;
   logic            load;

   alu_operations_e d_alu;
   logic            d_src, d_we, d_br, d_dst, d_mem, d_ill;

   assign opc = instr_i[6:0];
   assign f3  = instr_i[14:12];
   assign f7  = instr_i[31:25];

   assign imm_i = XLEN'($signed(instr_i[31:20]));
   assign imm_s = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
   assign imm_u = XLEN'($signed({instr_i[31:12], 12'h000}));
   assign imm_b = XLEN'($signed({instr_i[31], instr_i[7],
                                 instr_i[30:25], instr_i[11:8],
                                 1'b0}));

   assign imm_sel = (opc == OPC_STORE) ? imm_s :
                    (opc == OPC_LUI)   ? imm_u : imm_i;

   assign instr_ready_o = !dec_valid_o || dec_ready_i;
   assign accept        = instr_valid_i && instr_ready_o;
   assign load          = accept && !flush_i;

   // Combinational opcode/funct decode; illegal encodings squash all controls
   always_comb begin
      d_alu = OP_NOP;
      d_src = 1'b0;
      d_we  = 1'b0;
      d_br  = 1'b0;
      d_dst = 1'b0;
      d_mem = 1'b0;
      d_ill = 1'b0;
      unique case (opc)
         OPC_OP: begin
            d_we = 1'b1;
            unique case (f3)
               3'b000: d_alu = f7[5] ? OP_SUB : OP_ADD;
               3'b001: d_alu = OP_SLL;
               3'b010: d_alu = OP_SLT;
               3'b011: d_alu = OP_SLTU;
               3'b100: d_alu = OP_XOR;
               3'b101: d_alu = f7[5] ? OP_SRA : OP_SRL;
               3'b110: d_alu = OP_OR;
               3'b111: d_alu = OP_AND;
            endcase
            if (!(f7 == 7'b0000000 ||
                  (f7 == 7'b0100000 &&
                   (f3 == 3'b000 || f3 == 3'b101))))
               d_ill = 1'b1;
         end
         OPC_IMM: begin
            d_we  = 1'b1;
            d_src = 1'b1;
            unique case (f3)
               3'b000: d_alu = OP_ADD;
               3'b001: begin
                  d_alu = OP_SLL;
                  d_ill = |instr_i[31:26];
               end
               3'b010: d_alu = OP_SLT;
               3'b011: d_alu = OP_SLTU;
               3'b100: d_alu = OP_XOR;
               3'b101: begin
                  d_alu = instr_i[30] ? OP_SRA : OP_SRL;
                  d_ill = |{instr_i[31], instr_i[29:26]};
               end
               3'b110: d_alu = OP_OR;
               3'b111: d_alu = OP_AND;
            endcase
         end
         OPC_LOAD: begin
            d_alu = OP_ADD;
            d_src = 1'b1;
            d_dst = 1'b1;
            d_we  = 1'b1;
            d_ill = (f3 != 3'b010);
         end
         OPC_STORE: begin
            d_alu = OP_ADD;
            d_src = 1'b1;
            d_mem = 1'b1;
            d_ill = (f3 != 3'b010);
         end
         OPC_BRANCH: begin
            d_alu = OP_SUB;
            d_br  = 1'b1;
            d_ill = (f3 != 3'b000);
         end
         OPC_LUI: begin
            d_alu = OP_ADD;
            d_src = 1'b1;
            d_we  = 1'b1;
         end
         default: d_ill = 1'b1;
      endcase
      if (d_ill) begin
         d_alu = OP_NOP;
         d_src = 1'b0;
         d_we  = 1'b0;
         d_br  = 1'b0;
         d_dst = 1'b0;
         d_mem = 1'b0;
      end
   end

   // Stage occupancy and downstream transfer counter; flush wins
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dec_valid_o <= 1'b0;
         dec_count_o <= '0;
      end else begin
         if (dec_valid_o && dec_ready_i)
            dec_count_o <= dec_count_o + 1'b1;
         if (flush_i)
            dec_valid_o <= 1'b0;
         else if (accept)
            dec_valid_o <= 1'b1;
         else if (dec_ready_i)
            dec_valid_o <= 1'b0;
      end
   end

   // Decoded payload, captured only on a non-flushed accept
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rs_addr_a_o     <= '0;
         rs_addr_b_o     <= '0;
         rd_addr_o       <= '0;
         imm_o           <= '0;
         branch_target_o <= '0;
         alu_ctrl_o      <= OP_NOP;
         alu_src_o       <= 1'b0;
         rd_we_o         <= 1'b0;
         branch_o        <= 1'b0;
         alu_dst_o       <= 1'b0;
         mem_we_o        <= 1'b0;
         illegal_o       <= 1'b0;
      end else if (load) begin
         rs_addr_a_o     <= instr_i[19:15];
         rs_addr_b_o     <= instr_i[24:20];
         rd_addr_o       <= instr_i[11:7];
         imm_o           <= imm_sel;
         branch_target_o <= pc_i + imm_b;
         alu_ctrl_o      <= d_alu;
         alu_src_o       <= d_src;
         rd_we_o         <= d_we;
         branch_o        <= d_br;
         alu_dst_o       <= d_dst;
         mem_we_o        <= d_mem;
         illegal_o       <= d_ill;
      end
   end
endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: directed and random checks of rv_decode_stage
// against a spec-level reference model (32-bit and 64-bit instances).
module tb_rv_decode_stage;
   import rv_pkg::*;

   typedef struct {
      logic            v;
      logic [4:0]      ra, rb, rd;
      logic [63:0]     imm, bt;
      alu_operations_e op;
      logic            src, we, br, dst, mem, ill;
   } dec_t;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        flush_i;
   logic        instr_valid_i;
   logic [31:0] instr_i;
   logic [63:0] pc_i;
   logic        dec_ready_i;

   logic            instr_ready_o, dec_valid_o;
   logic [4:0]      rs_a, rs_b, rd;
   logic [31:0]     imm, bt;
   alu_operations_e alu;
   logic            src, we, br, dst, mem, ill;
   logic [15:0]     cnt;

   logic            ready_w, valid_w;
   logic [4:0]      rs_a_w, rs_b_w, rd_w;
   logic [63:0]     imm_w, bt_w;
   alu_operations_e alu_w;
   logic            src_w, we_w, br_w, dst_w, mem_w, ill_w;
   logic [2:0]      cnt_w;

   int checks = 0;
   int failures = 0;
   dec_t m;
   int unsigned mcnt;

   always #5 clk = ~clk;

   rv_decode_stage #(.XLEN(32), .CNT_W(16)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
      .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
      .instr_i(instr_i), .pc_i(pc_i[31:0]),
      .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
      .rs_addr_a_o(rs_a), .rs_addr_b_o(rs_b), .rd_addr_o(rd),
      .imm_o(imm), .branch_target_o(bt), .alu_ctrl_o(alu),
      .alu_src_o(src), .rd_we_o(we), .branch_o(br),
      .alu_dst_o(dst), .mem_we_o(mem), .illegal_o(ill),
      .dec_count_o(cnt)
   );

   rv_decode_stage #(.XLEN(64), .CNT_W(3)) dut_w (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
      .instr_valid_i(instr_valid_i), .instr_ready_o(ready_w),
      .instr_i(instr_i), .pc_i(pc_i),
      .dec_valid_o(valid_w), .dec_ready_i(dec_ready_i),
      .rs_addr_a_o(rs_a_w), .rs_addr_b_o(rs_b_w), .rd_addr_o(rd_w),
      .imm_o(imm_w), .branch_target_o(bt_w), .alu_ctrl_o(alu_w),
      .alu_src_o(src_w), .rd_we_o(we_w), .branch_o(br_w),
      .alu_dst_o(dst_w), .mem_we_o(mem_w), .illegal_o(ill_w),
      .dec_count_o(cnt_w)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic dec_t ref_decode(input logic [31:0] w,
                                       input logic [63:0] pc);
      dec_t d;
      alu_operations_e tbl [8] = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU,
                                   OP_XOR, OP_SRL, OP_OR, OP_AND};
      int f3, f7, top6;
      longint ii, si, ui, bi;
      f3 = int'(w[14:12]);
      f7 = int'(w[31:25]);
      top6 = int'(w[31:26]);
      d.v = 1'b1;
      d.ra = w[19:15];
      d.rb = w[24:20];
      d.rd = w[11:7];
      d.op = OP_NOP;
      d.src = 0; d.we = 0; d.br = 0; d.dst = 0; d.mem = 0; d.ill = 0;
      ii = longint'(w[31:20]);
      if (w[31]) ii -= 4096;
      si = longint'({w[31:25], w[11:7]});
      if (w[31]) si -= 4096;
      ui = longint'(w[31:12]) * 4096;
      if (w[31]) ui -= 64'h1_0000_0000;
      bi = longint'({w[31], w[7], w[30:25], w[11:8], 1'b0});
      if (w[31]) bi -= 8192;
      d.bt = pc + 64'(bi);
      d.imm = (w[6:0] == 7'h23) ? 64'(si) :
              (w[6:0] == 7'h37) ? 64'(ui) : 64'(ii);
      case (w[6:0])
         7'h33: begin
            d.we = 1;
            if (f7 == 0) d.op = tbl[f3];
            else if (f7 == 32 && f3 == 0) d.op = OP_SUB;
            else if (f7 == 32 && f3 == 5) d.op = OP_SRA;
            else d.ill = 1;
         end
         7'h13: begin
            d.we = 1; d.src = 1;
            if (f3 == 1 && top6 != 0) d.ill = 1;
            else if (f3 == 5 && top6 == 16) d.op = OP_SRA;
            else if (f3 == 5 && top6 != 0) d.ill = 1;
            else d.op = tbl[f3];
         end
         7'h03: begin
            d.op = OP_ADD; d.src = 1; d.dst = 1; d.we = 1;
            d.ill = (f3 != 2);
         end
         7'h23: begin
            d.op = OP_ADD; d.src = 1; d.mem = 1;
            d.ill = (f3 != 2);
         end
         7'h63: begin
            d.op = OP_SUB; d.br = 1;
            d.ill = (f3 != 0);
         end
         7'h37: begin
            d.op = OP_ADD; d.src = 1; d.we = 1;
         end
         default: d.ill = 1;
      endcase
      if (d.ill) begin
         d.op = OP_NOP;
         d.src = 0; d.we = 0; d.br = 0; d.dst = 0; d.mem = 0;
      end
      return d;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w = $urandom;
      int k = $urandom_range(0, 9);
      logic [6:0] opcs [7] = '{7'h33, 7'h13, 7'h03, 7'h23,
                              7'h63, 7'h37, 7'h33};
      if (k < 7) begin
         w[6:0] = opcs[k];
         if (k == 0)
            w[31:25] = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
         if (k == 1 && $urandom_range(0, 1) == 1)
            w[31:26] = ($urandom_range(0, 1) == 1) ? 6'h10 : 6'h00;
         if ((k == 2 || k == 3) && $urandom_range(0, 3) != 0)
            w[14:12] = 3'b010;
         if (k == 4 && $urandom_range(0, 3) != 0)
            w[14:12] = 3'b000;
      end else if (k == 7) begin
         w = 32'h0;
      end
      return w;
   endfunction

   task automatic compare_all();
      check("ready", instr_ready_o, !m.v || dec_ready_i);
      check("ready64", ready_w, !m.v || dec_ready_i);
      check("valid", dec_valid_o, m.v);
      check("valid64", valid_w, m.v);
      check("count", cnt, 64'(mcnt % 65536));
      check("count_wrap", cnt_w, 64'(mcnt % 8));
      if (m.v) begin
         check("rs_a", rs_a, m.ra);
         check("rs_b", rs_b, m.rb);
         check("rd", rd, m.rd);
         check("imm", imm, m.imm[31:0]);
         check("btgt", bt, m.bt[31:0]);
         check("imm64", imm_w, m.imm);
         check("btgt64", bt_w, m.bt);
         check("alu", alu, m.op);
         check("src", src, m.src);
         check("we", we, m.we);
         check("br", br, m.br);
         check("dst", dst, m.dst);
         check("mem", mem, m.mem);
         check("ill", ill, m.ill);
      end
   endtask

   task automatic compare_reset();
      check("rst_valid", dec_valid_o, 0);
      check("rst_count", cnt, 0);
      check("rst_count64", cnt_w, 0);
      check("rst_regs", {rs_a, rs_b, rd}, 0);
      check("rst_imm", imm, 0);
      check("rst_btgt", bt, 0);
      check("rst_alu", alu, OP_NOP);
      check("rst_ctl", {src, we, br, dst, mem, ill}, 0);
      check("rst_imm64", imm_w, 0);
   endtask

   task automatic cyc(input logic iv, input logic [31:0] w,
                      input logic [63:0] pc, input logic rdy,
                      input logic fl);
      logic acc;
      @(negedge clk);
      instr_valid_i = iv;
      instr_i = w;
      pc_i = pc;
      dec_ready_i = rdy;
      flush_i = fl;
      #1;
      compare_all();
      acc = iv && (!m.v || rdy);
      if (m.v && rdy) mcnt++;
      if (fl) m.v = 0;
      else if (acc) m = ref_decode(w, pc);
      else if (rdy) m.v = 0;
      @(posedge clk);
   endtask

   int unsigned c0;

   initial begin
      rst_ni = 0; flush_i = 0; instr_valid_i = 0;
      instr_i = 0; pc_i = 0; dec_ready_i = 0;
      m.v = 0;
      mcnt = 0;
      #12;
      compare_reset();
      @(negedge clk);
      rst_ni = 1;
      #1;
      check("ready_after_reset", instr_ready_o, 1);

      cyc(1, 32'h002081B3, 64'h0, 1, 0);
      #1;
      check("add_rs_a", rs_a, 1);
      check("add_rs_b", rs_b, 2);
      check("add_rd", rd, 3);
      check("add_alu", alu, OP_ADD);
      check("add_we", we, 1);
      check("add_src", src, 0);
      cyc(1, 32'h402081B3, 64'h0, 1, 0);
      #1;
      check("sub_alu", alu, OP_SUB);
      cyc(1, 32'hFFF00293, 64'h0, 1, 0);
      #1;
      check("addi_imm", imm, 32'hFFFF_FFFF);
      check("addi_imm64", imm_w, 64'hFFFF_FFFF_FFFF_FFFF);
      check("addi_src", src, 1);
      check("addi_alu", alu, OP_ADD);
      check("addi_rd", rd, 5);
      cyc(1, 32'hFE208CE3, 64'h100, 1, 0);
      #1;
      check("beq_target", bt, 32'hF8);
      check("beq_target64", bt_w, 64'hF8);
      check("beq_br", br, 1);
      check("beq_alu", alu, OP_SUB);
      check("beq_we", we, 0);
      cyc(1, 32'h0, 64'h0, 1, 0);
      #1;
      check("zero_ill", ill, 1);
      check("zero_alu", alu, OP_NOP);
      check("zero_we_mem", {we, mem}, 0);
      cyc(0, 32'h0, 64'h0, 1, 0);
      #1;
      check("count_five", cnt, 5);

      c0 = mcnt;
      cyc(1, 32'h00308233, 64'h0, 1, 0);
      cyc(1, 32'h00A28313, 64'h0, 0, 0);
      #1;
      check("stall_ready", instr_ready_o, 0);
      cyc(1, 32'h00A28313, 64'h0, 0, 0);
      #1;
      check("stall_hold_rd", rd, 4);
      cyc(1, 32'h00A28313, 64'h0, 1, 0);
      cyc(1, 32'h0062A023, 64'h0, 1, 0);
      cyc(0, 32'h0, 64'h0, 1, 0);
      #1;
      check("b2b_count", cnt, 64'(c0 + 3));

      cyc(1, 32'h00308233, 64'h0, 1, 0);
      c0 = mcnt;
      cyc(0, 32'h0, 64'h0, 0, 1);
      #1;
      check("flush_stall_valid", dec_valid_o, 0);
      check("flush_stall_count", cnt, 64'(c0));
      cyc(1, 32'h00308233, 64'h0, 1, 1);
      #1;
      check("flush_accept_valid", dec_valid_o, 0);
      check("flush_accept_count", cnt, 64'(c0));

      cyc(1, 32'h00308233, 64'h0, 1, 0);
      cyc(0, 32'h0, 64'h0, 0, 0);
      @(negedge clk);
      #2;
      rst_ni = 0;
      #1;
      compare_reset();
      m.v = 0;
      mcnt = 0;
      @(negedge clk);
      rst_ni = 1;

      repeat (600)
         cyc($urandom_range(0, 9) < 7, rand_instr(),
             {$urandom, $urandom}, $urandom_range(0, 9) < 7,
             $urandom_range(0, 19) == 0);
      cyc(0, 32'h0, 64'h0, 1, 0);
      cyc(0, 32'h0, 64'h0, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rv_decode_stage.md
RV_DECODE_STAGE -- requirements
Module: rv_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width (32 or 64); immediates and branch target SHALL be XLEN wide.
REQ-002 Parameter CNT_W, default 16, width of the decoded-instruction counter.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 flush_i  input  1  discard held and incoming instruction.
REQ-006 instr_valid_i / instr_ready_o  input / output  1 / 1  upstream valid/ready handshake.
REQ-007 instr_i  input  32  instruction word; pc_i  input  XLEN  its PC.
REQ-008 dec_valid_o / dec_ready_i  output / input  1 / 1  downstream valid/ready handshake.
REQ-009 rs_addr_a_o, rs_addr_b_o, rd_addr_o  output  5 each  register addresses from instr[19:15], [24:20], [11:7].
REQ-010 imm_o  output  XLEN  sign-extended immediate: I, S or U format, selected by opcode.
REQ-011 branch_target_o  output  XLEN  pc_i + sign-extended B-immediate, computed modulo 2^XLEN.
REQ-012 alu_ctrl_o  output  rv_pkg::alu_operations_e  ALU operation. The enum SHALL be extended with OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT and OP_SLTU.
REQ-013 alu_src_o, rd_we_o, branch_o, alu_dst_o, mem_we_o, illegal_o  output  1 each  control bits. alu_src_o=1 selects the immediate; alu_dst_o=1 selects memory data as the rd source.
REQ-014 dec_count_o  output  CNT_W  number of decoded instructions accepted downstream.

Function
REQ-015 The stage SHALL be a single registered pipeline stage with 1-cycle latency. An instruction is accepted on cycle N when instr_valid_i && instr_ready_o. The decoded result SHALL appear with dec_valid_o=1 on cycle N+1.
REQ-016 instr_ready_o SHALL equal !dec_valid_o || dec_ready_i, combinationally. This gives full throughput with back-to-back transfers.
REQ-017 While dec_valid_o && !dec_ready_i, all outputs SHALL hold stable.
REQ-018 Opcode decode:
 - OP 0110011: R-type; ADD/SUB, AND, OR, XOR, SLL, SRL/SRA, SLT, SLTU.
 - OP-IMM 0010011: I-type equivalents; alu_src=1.
 - LOAD 0000011: funct3=010 only; OP_ADD, alu_src=1, alu_dst=1, rd_we=1.
 - STORE 0100011: funct3=010 only; S-imm, OP_ADD, alu_src=1, mem_we=1, rd_we=0.
 - BRANCH 1100011: funct3=000 (BEQ) only; OP_SUB, branch=1, rd_we=0.
 - LUI 0110111: U-imm, OP_ADD, alu_src=1, rd_we=1.
REQ-019 For OP, funct7 SHALL be 0000000, or 0100000 for ADD/SUB and SRL/SRA only. For OP-IMM shifts, instr[31:26] SHALL be 0, except instr[30]=1 for SRAI. Any other encoding is illegal.
REQ-020 Any unlisted opcode or funct combination SHALL set illegal_o=1 with alu_ctrl_o=OP_NOP and rd_we_o=mem_we_o=branch_o=alu_dst_o=alu_src_o=0. It still occupies the stage and handshakes normally.
REQ-021 flush_i=1 SHALL clear dec_valid_o on the next edge and block acceptance in that cycle. flush takes priority over a simultaneous accept and over a held stall.
REQ-022 dec_count_o SHALL increment by 1 on each dec_valid_o && dec_ready_i, counting legal and illegal alike. It SHALL wrap from 2^CNT_W-1 to 0.
REQ-023 With XLEN=64, imm_o and branch_target_o SHALL sign-extend from instr[31] across all XLEN bits.

Reset
REQ-024 On rst_ni=0, asynchronously: dec_valid_o=0, dec_count_o=0, all payload outputs=0, alu_ctrl_o=OP_NOP, illegal_o=0.
REQ-025 After rst_ni deasserts, instr_ready_o=1 on the first cycle.
REQ-026 Reset asserted mid-stall SHALL drop the held instruction, which is not counted.

Verification
REQ-027 Accept 0x002081B3 (add x3,x1,x2), dec_ready_i=1 -> next cycle: rs_a=1, rs_b=2, rd=3, OP_ADD, rd_we=1, alu_src=0; then 0x402081B3 -> OP_SUB.
REQ-028 Accept 0xFFF00293 (addi x5,x0,-1) -> imm_o=0xFFFFFFFF, alu_src=1, OP_ADD, rd=5.
REQ-029 Accept 0xFE208CE3 (beq x1,x2,-8) with pc_i=0x100 -> branch_target_o=0xF8, branch_o=1, OP_SUB, rd_we=0.
REQ-030 Three back-to-back instructions with dec_ready_i held 0 for 2 cycles -> outputs stable, instr_ready_o=0, no loss or duplication, dec_count_o=3 at the end.
REQ-031 Accept 0x00000000 -> illegal_o=1, OP_NOP, rd_we=0, mem_we=0, dec_count_o increments.
REQ-032 flush_i asserted during a stall, and separately with a simultaneous accept -> dec_valid_o=0 next cycle, count unchanged; rst_ni pulse mid-stall -> all outputs at reset values immediately.
